// File: rtl/matmul_seq.sv
// matmul_seq: sequencer for a small matrix multiply C = A * B.
// Loads A then B (row-major) into an external operand bank. For every C[i][j] it walks
// one CLR, INNER MAC cycles and one WRITE. The results are then drained over an
// out_valid/out_ready handshake. Only the control is generated here; the operand bank,
// the MAC unit and the result bank live outside and follow the select/enable outputs.
module matmul_seq #(
   parameter int unsigned ROWS  = 2,
   parameter int unsigned INNER = 3,
   parameter int unsigned COLS  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       din_valid,
   output logic       load_en,
   output logic [3:0] load_sel,
   output logic [3:0] a_sel,
   output logic [3:0] b_sel,
   output logic       mac_clr,
   output logic       mac_en,
   output logic       res_ld,
   output logic [1:0] res_sel,
   output logic       out_valid,
   output logic [1:0] out_sel,
   input  logic       out_ready,
   output logic       busy,
   output logic       done
);

   // Index arithmetic is done in 4 bits; the legal parameter range keeps every index
   // (operand bank <= 16 words, result bank <= 4 words) inside that width.
   localparam int unsigned NumWords = ROWS * INNER + INNER * COLS;
   localparam logic [3:0]  LastWord = 4'(NumWords - 1);
   localparam logic [3:0]  BBase    = 4'(ROWS * INNER);
   localparam logic [3:0]  InnerW   = 4'(INNER);
   localparam logic [3:0]  ColsW    = 4'(COLS);
   localparam logic [3:0]  LastK    = 4'(INNER - 1);
   localparam logic [3:0]  LastI    = 4'(ROWS - 1);
   localparam logic [3:0]  LastJ    = 4'(COLS - 1);
   localparam logic [1:0]  LastRes  = 2'(ROWS * COLS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StClr,
      StMac,
      StWrite,
      StDrain,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] load_q, load_d;    // operand word being loaded
   logic [3:0] i_q, i_d;          // result row
   logic [3:0] j_q, j_d;          // result column
   logic [3:0] k_q, k_d;          // MAC term within the current result
   logic [1:0] drain_q, drain_d;  // result word being offered downstream

   // Next-state and counter update; abort outside IDLE overrides everything.
   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      drain_d = drain_q;

      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
         load_d  = '0;
         i_d     = '0;
         j_d     = '0;
         k_d     = '0;
         drain_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start && !abort) begin
                  state_d = StLoad;
                  load_d  = '0;
               end
            end

            StLoad: begin
               if (din_valid) begin
                  if (load_q == LastWord) begin
                     state_d = StClr;
                     load_d  = '0;
                     i_d     = '0;
                     j_d     = '0;
                  end else begin
                     load_d = load_q + 4'd1;
                  end
               end
            end

            StClr: begin
               k_d     = '0;
               state_d = StMac;
            end

            StMac: begin
               if (k_q == LastK) begin
                  k_d     = '0;
                  state_d = StWrite;
               end else begin
                  k_d = k_q + 4'd1;
               end
            end

            StWrite: begin
               if (j_q == LastJ) begin
                  j_d = '0;
                  if (i_q == LastI) begin
                     i_d     = '0;
                     drain_d = '0;
                     state_d = StDrain;
                  end else begin
                     i_d     = i_q + 4'd1;
                     state_d = StClr;
                  end
               end else begin
                  j_d     = j_q + 4'd1;
                  state_d = StClr;
               end
            end

            StDrain: begin
               if (out_ready) begin
                  if (drain_q == LastRes) begin
                     drain_d = '0;
                     state_d = StDone;
                  end else begin
                     drain_d = drain_q + 2'd1;
                  end
               end
            end

            StDone: begin
               state_d = StIdle;
            end

            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // State and counter registers, asynchronously cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         load_q  <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         drain_q <= drain_d;
      end
   end

   // Output decode from registered state; load_en is the only input-dependent output.
   always_comb begin
      load_en   = 1'b0;
      load_sel  = '0;
      a_sel     = '0;
      b_sel     = '0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      res_ld    = 1'b0;
      res_sel   = '0;
      out_valid = 1'b0;
      out_sel   = '0;
      done      = 1'b0;
      busy      = (state_q != StIdle);

      case (state_q)
         StLoad: begin
            load_en  = din_valid;
            load_sel = load_q;
         end
         StClr: begin
            mac_clr = 1'b1;
         end
         StMac: begin
            mac_en = 1'b1;
            a_sel  = i_q * InnerW + k_q;
            b_sel  = BBase + k_q * ColsW + j_q;
         end
         StWrite: begin
            res_ld  = 1'b1;
            res_sel = 2'(i_q * ColsW + j_q);
         end
         StDrain: begin
            out_valid = 1'b1;
            out_sel   = drain_q;
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: random operand words are pushed through the sequencer. A bench-side
// datapath (operand bank, accumulator, result bank) follows the DUT's control outputs,
// and the delivered results are compared with C = A * B computed directly from the words.
module tb_matmul_seq;

   localparam int unsigned ROWS  = 2;
   localparam int unsigned INNER = 3;
   localparam int unsigned COLS  = 2;
   localparam int NW = ROWS * INNER + INNER * COLS;
   localparam int NR = ROWS * COLS;

   logic       clk, reset, start, abort, din_valid, out_ready;
   logic       load_en, mac_clr, mac_en, res_ld, out_valid, busy, done;
   logic [3:0] load_sel, a_sel, b_sel;
   logic [1:0] res_sel, out_sel;
   logic [7:0] din_data;

   int n_checks, n_fail;
   int cyc;

   // Bench datapath driven by the DUT's control outputs
   logic [7:0] bank [16];
   int         acc;
   int         resbank [4];

   // Per-run event logs
   int q_load[$], q_a[$], q_b[$], q_res[$], q_out[$], q_out_cyc[$], q_stall[$], q_val[$];
   int words[$];
   int first_clr_cyc, last_load_cyc, last_res_cyc, done_cyc, n_done;
   bit got;

   matmul_seq #(.ROWS(ROWS), .INNER(INNER), .COLS(COLS)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .din_valid (din_valid),
      .load_en   (load_en),
      .load_sel  (load_sel),
      .a_sel     (a_sel),
      .b_sel     (b_sel),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .res_ld    (res_ld),
      .res_sel   (res_sel),
      .out_valid (out_valid),
      .out_sel   (out_sel),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_logs();
      q_load.delete(); q_a.delete(); q_b.delete(); q_res.delete();
      q_out.delete(); q_out_cyc.delete(); q_stall.delete(); q_val.delete();
      words.delete();
      first_clr_cyc = -1;
      last_load_cyc = -1;
      last_res_cyc  = -1;
      done_cyc      = -1;
      n_done        = 0;
   endtask

   // Monitor on the falling edge: log events and run the bench datapath.
   initial begin
      cyc = 0;
      acc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            if (load_en) begin
               q_load.push_back(int'(load_sel));
               bank[load_sel] = din_data;
               last_load_cyc = cyc;
            end
            if (mac_clr) begin
               acc = 0;
               if (first_clr_cyc < 0) first_clr_cyc = cyc;
            end
            if (mac_en) begin
               q_a.push_back(int'(a_sel));
               q_b.push_back(int'(b_sel));
               acc = acc + int'(bank[a_sel]) * int'(bank[b_sel]);
            end
            if (res_ld) begin
               q_res.push_back(int'(res_sel));
               resbank[res_sel] = acc;
               last_res_cyc = cyc;
            end
            if (out_valid && out_ready) begin
               q_out.push_back(int'(out_sel));
               q_val.push_back(resbank[out_sel]);
               q_out_cyc.push_back(cyc);
            end
            if (out_valid && !out_ready) q_stall.push_back(int'(out_sel));
            if (done) begin
               n_done++;
               done_cyc = cyc;
            end
         end
      end
   end

   // Feed NW words; stall toggles din_valid 1,0,1,0...  Called at posedge+1 in LOAD.
   task automatic load_words(input bit stall);
      int accepted;
      accepted = 0;
      for (int g = 0; g < 64 && accepted < NW; g++) begin
         din_valid = stall ? (g % 2 == 0) : 1'b1;
         din_data  = 8'($urandom_range(0, 255));
         #2;
         check_eq("load_en_mirror", 32'(load_en), 32'(din_valid));
         check_eq("load_sel", 32'(load_sel), accepted);
         if (din_valid) begin
            words.push_back(int'(din_data));
            accepted++;
         end
         @(posedge clk) #1;
      end
      din_valid = 1'b0;
      check_eq("clr_after_load", 32'(mac_clr), 1);
   endtask

   // Wait for done; bp stalls the handshake for 5 cycles while out_sel is 1.
   task automatic wait_done(input int budget, input bit bp, output bit seen);
      int stalls;
      stalls = 0;
      seen   = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (bp && out_valid && out_sel == 2'd1 && stalls < 5) begin
            out_ready = 1'b0;
            stalls++;
         end else begin
            out_ready = 1'b1;
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk) #1;
      end
      check_eq("done_seen", 32'(seen), 1);
   endtask

   task automatic do_run(input bit stall, input bit bp, input bit hold, output bit seen);
      clear_logs();
      start = 1'b1;
      @(posedge clk) #1;
      if (!hold) start = 1'b0;
      check_eq("busy_in_load", 32'(busy), 1);
      load_words(stall);
      wait_done(400, bp, seen);
   endtask

   // Compare the logs of a complete run with values derived from the matrix rules.
   task automatic verify_run(input bit bp);
      int idx, cexp;
      check_eq("load_count", q_load.size(), NW);
      for (int n = 0; n < NW && n < q_load.size(); n++) check_eq("load_seq", q_load[n], n);
      check_eq("mac_count", q_a.size(), NR * INNER);
      idx = 0;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++)
            for (int k = 0; k < INNER; k++) begin
               if (idx < q_a.size()) begin
                  check_eq("a_sel", q_a[idx], i * INNER + k);
                  check_eq("b_sel", q_b[idx], ROWS * INNER + k * COLS + j);
               end
               idx++;
            end
      check_eq("res_count", q_res.size(), NR);
      for (int n = 0; n < NR && n < q_res.size(); n++) check_eq("res_sel", q_res[n], n);
      check_eq("out_count", q_out.size(), NR);
      for (int n = 0; n < NR && n < q_out.size(); n++) begin
         cexp = 0;
         if (words.size() == NW)
            for (int k = 0; k < INNER; k++)
               cexp += words[(n / COLS) * INNER + k] * words[ROWS * INNER + k * COLS + n % COLS];
         check_eq("out_sel", q_out[n], n);
         check_eq("result", q_val[n], cexp);
      end
      if (!bp && q_out.size() == NR)
         check_eq("drain_back2back", q_out_cyc[NR-1] - q_out_cyc[0], NR - 1);
      if (bp) begin
         check_eq("stall_cycles", q_stall.size(), 5);
         foreach (q_stall[n]) check_eq("stall_sel", q_stall[n], 1);
      end
      check_eq("done_pulses", n_done, 1);
      if (q_out.size() > 0) check_eq("done_after_drain", done_cyc, q_out_cyc[$] + 1);
      check_eq("first_clr_latency", first_clr_cyc, last_load_cyc + 1);
      check_eq("compute_cycles", last_res_cyc - first_clr_cyc + 1, NR * (INNER + 2));
   endtask

   task automatic abort_run();
      int  mac_n;
      bit  hit;
      clear_logs();
      mac_n = 0;
      hit   = 1'b0;
      start = 1'b1;
      @(posedge clk) #1;
      start = 1'b0;
      load_words(1'b0);
      for (int c = 0; c < 100 && !hit; c++) begin
         if (mac_en) begin
            mac_n++;
            if (mac_n == 8) begin
               check_eq("abort_a_sel", 32'(a_sel), 4);
               check_eq("abort_b_sel", 32'(b_sel), 8);
               abort = 1'b1;
               hit   = 1'b1;
            end
         end
         @(posedge clk) #1;
      end
      if (!hit) begin
         abort = 1'b1;
         @(posedge clk) #1;
      end
      abort = 1'b0;
      check_eq("abort_hit", 32'(hit), 1);
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_res_ld", 32'(res_ld), 0);
      check_eq("abort_done", 32'(done), 0);
      repeat (4) begin
         @(posedge clk) #1;
         check_eq("abort_stays_idle", 32'(busy), 0);
      end
      check_eq("abort_res_count", q_res.size(), 2);
      check_eq("abort_no_done", n_done, 0);
   endtask

   task automatic reset_in_drain();
      clear_logs();
      start = 1'b1;
      @(posedge clk) #1;
      start = 1'b0;
      load_words(1'b0);
      out_ready = 1'b0;
      for (int c = 0; c < 200 && !out_valid; c++) @(posedge clk) #1;
      check_eq("drain_reached", 32'(out_valid), 1);
      #3 reset = 1'b1;
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_busy", 32'(busy), 0);
      #3 reset = 1'b0;
      @(posedge clk) #1;
      repeat (4) begin
         check_eq("rst_stays_idle", 32'(busy), 0);
         @(posedge clk) #1;
      end
      out_ready = 1'b1;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      din_valid = 1'b1;
      out_ready = 1'b0;
      din_data  = '0;
      clear_logs();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_load_en", 32'(load_en), 0);
      check_eq("rst_strobes", 32'({mac_clr, mac_en, res_ld, out_valid, done}), 0);
      check_eq("rst_selects", 32'({load_sel, a_sel, b_sel, res_sel, out_sel}), 0);
      din_valid = 1'b0;
      reset     = 1'b0;
      @(posedge clk) #1;
      check_eq("idle_no_start", 32'(busy), 0);

      // basic flow, load stall, drain backpressure
      do_run(1'b0, 1'b0, 1'b0, got);
      @(posedge clk) #1;
      check_eq("idle_after_done", 32'(busy), 0);
      verify_run(1'b0);

      do_run(1'b1, 1'b0, 1'b0, got);
      @(posedge clk) #1;
      verify_run(1'b0);

      do_run(1'b0, 1'b1, 1'b0, got);
      @(posedge clk) #1;
      verify_run(1'b1);

      // abort in MAC, then a fresh run
      abort_run();
      do_run(1'b0, 1'b0, 1'b0, got);
      @(posedge clk) #1;
      verify_run(1'b0);

      // start together with abort in IDLE stays idle
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk) #1;
      start = 1'b0;
      abort = 1'b0;
      check_eq("abort_beats_start", 32'(busy), 0);

      // async reset while draining, then a fresh run
      reset_in_drain();
      do_run(1'b0, 1'b0, 1'b0, got);
      @(posedge clk) #1;
      verify_run(1'b0);

      // start held high: one IDLE cycle, then LOAD again
      do_run(1'b0, 1'b0, 1'b1, got);
      @(posedge clk) #1;
      check_eq("hold_idle_gap", 32'(busy), 0);
      @(posedge clk) #1;
      check_eq("hold_reload_busy", 32'(busy), 1);
      check_eq("hold_reload_sel", 32'(load_sel), 0);
      verify_run(1'b0);
      start = 1'b0;
      abort = 1'b1;
      @(posedge clk) #1;
      abort = 1'b0;
      check_eq("abort_in_load", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
